fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the ID-stage branch resolution unit. It owns the PC register, selects the next PC from the branch unit's address-select and targets, drives a wait-state-capable instruction-memory request, and produces the IF/ID pipeline register. It honours hazard-unit stalls, including a one-entry hold buffer for an instruction returned during a stall, and branch-unit flushes.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- address_select  in  2  next-PC select from branch unit: 00 PC+4, 01 branch_target, 10 jump_target, 11 reserved (treated as 00)
- branch_target  in  32  branch destination
- jump_target  in  32  jump destination
- ifid_flush  in  1  clear IF/ID to bubble (from branch unit)
- ifid_stall  in  1  hold PC and IF/ID (from hazard unit)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (equals PC)
- imem_ready  in  1  rdata valid for imem_addr this cycle; sampled only while imem_req=1
- imem_rdata  in  32  fetched instruction
- ifid_instr  out  32  IF/ID instruction
- ifid_pc_plus4  out  32  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc, state {START, FETCH, HOLD}, hold_instr, IF/ID outputs.
- Reset (async, rst_n=0): pc=RESET_PC, state=START, hold_instr=0, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0. imem_req=0.
- imem_req = (state==FETCH); imem_addr = pc always.
- START: go to FETCH next edge; nothing else changes.
- Redirect condition: address_select in {01,10} and ifid_stall=0. Checked first in FETCH and HOLD. Action: pc<=selected target, IF/ID<=bubble (instr 0, pc_plus4 0, valid 0), hold_instr discarded, state<=FETCH. Any imem_rdata returned that cycle is dropped.
- ifid_stall=1 overrides address_select and ifid_flush: pc and IF/ID unchanged.
- FETCH, no redirect:
  - ready=1, stall=0: IF/ID<={imem_rdata, pc+4, 1}; pc<=pc+4.
  - ready=1, stall=1: hold_instr<=imem_rdata; state<=HOLD; pc and IF/ID unchanged.
  - ready=0, stall=0: IF/ID<=bubble; pc unchanged.
  - ready=0, stall=1: everything unchanged.
- HOLD (imem_req=0), no redirect:
  - stall=1: remain.
  - stall=0: IF/ID<={hold_instr, pc+4, 1}; pc<=pc+4; state<=FETCH.
- ifid_flush=1 with stall=0 and no redirect: IF/ID<=bubble instead of any load. pc still advances as above, so an instruction completing or leaving HOLD that cycle is consumed and dropped.
- Arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 0. No alignment check; targets are taken as given.
- Memory contract: addr is held stable until ready, except on redirect, when the pending request is abandoned. The memory keeps no outstanding transaction.

## Timing
- Zero-wait memory (ready tied 1): one instruction per cycle. IF/ID is updated on the edge ending the cycle in which ready=1.
- First request is one cycle after rst_n deasserts (START cycle).
- N wait cycles give N bubbles in IF/ID.
- Taken branch/jump: redirect on the edge ending the cycle in which the branch unit asserts it. imem_addr shows the target the next cycle. One bubble enters ID.
- HOLD release: IF/ID loads on the first edge with stall=0. The next request is issued in the following cycle.
- Async reset mid-HOLD or mid-FETCH: immediate return to reset values. Held instruction is lost.

## Test plan
- Reset: rst_n=0 with clk running -> all outputs 0, imem_req=0. After release -> START for 1 cycle, then imem_req=1, imem_addr=0.
- Zero-wait stream, ready=1, rdata=addr^32'hA5A5_0000 -> ifid_pc_plus4 = 4, 8, 12 on consecutive edges, valid=1, instr matches.
- Wait states: ready=0 for 2 cycles at addr 0x8 -> imem_addr held at 0x8, ifid_valid=0 for 2 cycles, then instr@0x8 with pc_plus4=0xC.
- Stall hold: stall=1 in the cycle ready returns instr@0x8 -> HOLD, imem_req=0, IF/ID frozen for 3 stall cycles. Release -> IF/ID={instr@0x8, 0xC, 1}, next imem_addr=0xC.
- Redirect: address_select=01, branch_target=0x40, flush=1 -> next cycle imem_addr=0x40, ifid_valid=0. address_select=10 to 0x100 behaves the same. address_select=11 -> sequential PC+4.
- Priority: address_select=01 with stall=1 -> pc unchanged. Redirect in HOLD -> hold_instr dropped, fetch at target. rst_n pulsed low mid-HOLD -> reset values, pc=RESET_PC.

Source files
------------

// File: rtl/imem_if.sv
// Instruction-memory request bus between fetch and imem.
// Request is held until ready unless fetch abandons it on redirect.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, imem request, IF/ID register.
// One-entry hold buffer keeps an instruction that returned during a stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  address_select_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  input  logic        ifid_flush_i,
  input  logic        ifid_stall_i,
  imem_if.master      imem,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        ifid_valid_o
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = (address_select_i == 2'b10)
                  ? jump_target_i : branch_target_i;
  // Stall beats a redirect; 2'b11 falls through as sequential.
  assign redirect = !ifid_stall_i
                  && (address_select_i == 2'b01
                   || address_select_i == 2'b10);

  assign imem.req  = (state_q == FETCH);
  assign imem.addr = pc_q;

  assign ifid_instr_o    = instr_q;
  assign ifid_pc_plus4_o = pc4_q;
  assign ifid_valid_o    = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START;
      pc_q    <= RESET_PC;
      hold_q  <= 32'd0;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        START: state_q <= FETCH;
        FETCH, HOLD: begin
          if (redirect) begin
            pc_q    <= target;
            hold_q  <= 32'd0;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end else if (!ifid_stall_i) begin
            if (state_q == HOLD || imem.ready) begin
              pc_q    <= pc_plus4;
              state_q <= FETCH;
              if (ifid_flush_i) begin
                instr_q <= 32'd0;
                pc4_q   <= 32'd0;
                valid_q <= 1'b0;
              end else begin
                instr_q <= (state_q == HOLD)
                         ? hold_q : imem.rdata;
                pc4_q   <= pc_plus4;
                valid_q <= 1'b1;
              end
            end else begin
              instr_q <= 32'd0;
              pc4_q   <= 32'd0;
              valid_q <= 1'b0;
            end
          end else if (state_q == FETCH
                    && imem.ready) begin
            hold_q  <= imem.rdata;
            state_q <= HOLD;
          end
        end
        default: state_q <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem answers addr ^ 32'hA5A5_0000.
// Inputs change and outputs are sampled 2ns after each rising edge.
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [31:0] bt;
  logic [31:0] jt;
  logic        flush;
  logic        stall;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        valid;
  int          passed;
  int          total;

  imem_if imem ();

  assign imem.ready = ready;
  assign imem.rdata = imem.addr ^ 32'hA5A5_0000;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .address_select_i (sel),
    .branch_target_i  (bt),
    .jump_target_i    (jt),
    .ifid_flush_i     (flush),
    .ifid_stall_i     (stall),
    .imem             (imem),
    .ifid_instr_o     (instr),
    .ifid_pc_plus4_o  (pc4),
    .ifid_valid_o     (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [31:0] ei,
                          input logic [31:0] ep,
                          input logic ev);
    chk({tag, "_instr"}, instr, ei);
    chk({tag, "_pc4"}, pc4, ep);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
  endtask

  task automatic chk_bus(input string tag,
                         input logic er,
                         input logic [31:0] ea);
    chk({tag, "_req"}, {31'd0, imem.req}, {31'd0, er});
    chk({tag, "_addr"}, imem.addr, ea);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    sel    = 2'b00;
    bt     = 32'd0;
    jt     = 32'd0;
    flush  = 1'b0;
    stall  = 1'b0;
    ready  = 1'b1;

    tick();
    tick();
    chk_bus("rst", 1'b0, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);

    rst_n = 1'b1;
    #1;
    chk_bus("start", 1'b0, 32'h0);
    tick();
    chk_bus("first", 1'b1, 32'h0);

    tick();
    chk_ifid("zw0", 32'hA5A5_0000, 32'h4, 1'b1);
    tick();
    chk_ifid("zw1", 32'hA5A5_0004, 32'h8, 1'b1);
    chk_bus("zw1", 1'b1, 32'h8);

    ready = 1'b0;
    tick();
    chk_ifid("ws0", 32'h0, 32'h0, 1'b0);
    chk_bus("ws0", 1'b1, 32'h8);
    tick();
    chk_ifid("ws1", 32'h0, 32'h0, 1'b0);
    chk_bus("ws1", 1'b1, 32'h8);
    ready = 1'b1;
    tick();
    chk_ifid("ws2", 32'hA5A5_0008, 32'hC, 1'b1);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bus("hold", 1'b0, 32'hC);
      chk_ifid("hold", 32'hA5A5_0008, 32'hC, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk_ifid("hrel", 32'hA5A5_000C, 32'h10, 1'b1);
    chk_bus("hrel", 1'b1, 32'h10);

    sel = 2'b01; bt = 32'h40; flush = 1'b1;
    tick();
    chk_bus("br", 1'b1, 32'h40);
    chk_ifid("br", 32'h0, 32'h0, 1'b0);
    sel = 2'b10; jt = 32'h100;
    tick();
    chk_bus("jmp", 1'b1, 32'h100);
    chk_ifid("jmp", 32'h0, 32'h0, 1'b0);
    sel = 2'b11; flush = 1'b0;
    tick();
    chk_bus("sel11", 1'b1, 32'h104);
    chk_ifid("sel11", 32'hA5A5_0100, 32'h104, 1'b1);

    sel = 2'b01; bt = 32'h40; stall = 1'b1; ready = 1'b0;
    tick();
    chk_bus("stpri", 1'b1, 32'h104);
    chk_ifid("stpri", 32'hA5A5_0100, 32'h104, 1'b1);

    sel = 2'b00; ready = 1'b1;
    tick();
    chk_bus("hold2", 1'b0, 32'h104);
    sel = 2'b01; bt = 32'h200; stall = 1'b0;
    tick();
    chk_bus("hredir", 1'b1, 32'h200);
    chk_ifid("hredir", 32'h0, 32'h0, 1'b0);
    sel = 2'b00;
    tick();
    chk_ifid("tgt", 32'hA5A5_0200, 32'h204, 1'b1);

    flush = 1'b1;
    tick();
    chk_ifid("flush", 32'h0, 32'h0, 1'b0);
    chk_bus("flush", 1'b1, 32'h208);
    flush = 1'b0;

    stall = 1'b1;
    tick();
    chk_bus("hold3", 1'b0, 32'h208);
    rst_n = 1'b0;
    #1;
    chk_bus("arst", 1'b0, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    stall = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_bus("rerun", 1'b1, 32'h0);
    tick();
    chk_ifid("rerun", 32'hA5A5_0000, 32'h4, 1'b1);

    sel = 2'b10; jt = 32'hFFFF_FFFC;
    tick();
    chk_bus("wrapj", 1'b1, 32'hFFFF_FFFC);
    sel = 2'b00;
    tick();
    chk_ifid("wrap", 32'h5A5A_FFFC, 32'h0, 1'b1);
    chk_bus("wrap", 1'b1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
